apb_splitter_wdog: RTL
======================

# apb_splitter_wdog

APB3 one-to-N splitter for the example SoC peripheral bus, sitting between the APB bridge and the peripheral slaves. It adds what the plain splitter lacks:
- priority address decode, so overlapping windows are legal;
- slave select latched at the setup phase;
- a clean zero-wait error response for unmapped addresses;
- a per-transfer watchdog that terminates hung slaves with PSLVERR;
- sticky error status with address capture for the debug/IRQ path.

## Interface
- W_ADDR, 16: address width.
- W_DATA, 32: data width.
- N_SLAVES, 3: number of downstream slaves, 1..16.
- ADDR_MAP, 48'h4000_2000_0000: N_SLAVES×W_ADDR packed match values; slave i in bits [i*W_ADDR +: W_ADDR].
- ADDR_MASK, 48'he000_e000_e000: packed masks. Slave i hits when (paddr & mask_i) == map_i.
- TIMEOUT, 256: access-phase cycles before abort. 0 disables the watchdog.
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- apbs_paddr/psel/penable/pwrite/pwdata  in  W_ADDR/1/1/1/W_DATA  upstream APB request.
- apbs_pready/prdata/pslverr  out  1/W_DATA/1  upstream APB response.
- apbm_paddr  out  N_SLAVES*W_ADDR  broadcast address.
- apbm_pwdata  out  N_SLAVES*W_DATA  broadcast write data.
- apbm_psel/penable/pwrite  out  N_SLAVES each  per-slave, one-hot gated.
- apbm_pready/prdata/pslverr  in  N_SLAVES/N_SLAVES*W_DATA/N_SLAVES  per-slave response.
- err_clr  in  1  one-cycle pulse; clears err_status.
- err_status  out  2  sticky flags: bit0 unmapped, bit1 timeout.
- err_addr  out  W_ADDR  paddr of the first error since the last clear.
- err_slave  out  4  slave index of the first timeout.

## Operation
- Decode: hit vector computed from apbs_paddr. The lowest-index hit wins, giving a one-hot select. No hit means unmapped.
- FSM states: IDLE, ACCESS, UNMAPPED.
- IDLE: on psel & !penable (setup phase), latch the one-hot select into sel_q and clear the watchdog counter.
  - Go to UNMAPPED if the decode has no hit, else go to ACCESS.
- During setup, downstream psel uses the live decode. During access it uses sel_q.
- apbm_penable/pwrite = sel & apbs_penable/pwrite. paddr and pwdata are broadcast unconditionally.
- ACCESS: upstream response is muxed from sel_q.
  - Each cycle with the selected pready low, the counter increments.
  - If the counter equals TIMEOUT-1 while pready is low: drive apbs_pready=1, apbs_pslverr=1, apbs_prdata=0, set err_status[1], then return to IDLE.
  - If the selected pready is high: pass the slave's response through and return to IDLE.
- UNMAPPED, first access cycle: apbs_pready=1, apbs_pslverr=1, apbs_prdata=0, set err_status[0], return to IDLE. No apbm_psel is asserted at any point.
- Outside a transfer: apbs_pready=1, apbs_pslverr=0, apbs_prdata=0.
- Error capture: err_addr and err_slave load only when err_status==0 before the error. err_slave is captured on timeouts only.

## Timing
- Reset values: sel_q=0, counter=0, state=IDLE, err_status=0, err_addr=0, err_slave=0.
  - All apbm_psel/penable/pwrite are 0 while psel is low.
  - apbs_pready=1, apbs_pslverr=0, apbs_prdata=0.
- Latency: zero added wait states. Responses are combinational from the slave.
- Hung slave: completes on access cycle number TIMEOUT, so TIMEOUT=4 gives pslverr on the 4th access cycle. The abandoned slave sees psel drop and must tolerate it.
- Slave pready rising in the same cycle the timeout would fire: the slave response wins, no error.
- err_clr in the same cycle as a new error: set wins, and capture registers load the new error.
- rst_n low mid-transfer: immediate return to reset values. Downstream psel gating falls with sel_q.
- Counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.

## Structure
- Shared header apb_fabric_defs.vh holds:
  - FSM state encodings;
  - error bit indices ERR_UNMAPPED=0 and ERR_TIMEOUT=1.
- Sub-module apb_priority_decode: parametrised masked-compare plus lowest-index priority, outputting a one-hot vector, a hit flag and an index.
- Existing onehot_mux handles prdata.

## Test plan
- Write to slave 1 (paddr 0x2004), slave pready after 2 wait states -> only apbm_psel[1] asserted, upstream completes on access cycle 3, pslverr=0.
- Read of unmapped 0x8000 -> pready=1, pslverr=1, prdata=0 in the first access cycle, no apbm_psel toggles, err_status=01, err_addr=0x8000.
- TIMEOUT=4, slave 0 pready stuck low -> pslverr on the 4th access cycle, err_status=10, err_slave=0. A following transfer to slave 2 succeeds.
- Overlapping maps, slaves 0 and 2 both hit 0x4010 -> slave 0 selected only.
- Slave pready high exactly on the timeout cycle -> normal response, err_status unchanged. err_clr coincident with a second unmapped access -> err_status=01, err_addr updated.
- rst_n pulsed low mid-access -> all outputs at reset values asynchronously. The next transfer decodes correctly.

Source files
------------

// File: rtl/apb_splitter_wdog_pkg.sv
// apb_splitter_wdog_pkg: shared FSM encoding, error bit indices and counter sizing helper
package apb_splitter_wdog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_UNMAPPED = 2'd2
    } state_t;

    localparam int ERR_UNMAPPED = 0;
    localparam int ERR_TIMEOUT  = 1;

    // Watchdog counter must hold TIMEOUT; a disabled watchdog still needs a 1-bit vector
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_priority_decode.sv
// apb_priority_decode: masked address compare with lowest-index-wins priority
module apb_priority_decode #(
    parameter int                  W_ADDR = 16,
    parameter int                  N      = 3,
    parameter logic [N*W_ADDR-1:0] MAP    = '0,
    parameter logic [N*W_ADDR-1:0] MASK   = '0
) (
    input  logic [W_ADDR-1:0] i_addr,
    output logic [N-1:0]      o_onehot,
    output logic              o_hit,
    output logic [3:0]        o_idx
);

    logic [N-1:0] w_hit;

    // Scan from the top index down so the lowest matching window is the one left standing
    always_comb begin
        w_hit    = '0;
        o_onehot = '0;
        o_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_hit[i] = (i_addr & MASK[i*W_ADDR +: W_ADDR]) == MAP[i*W_ADDR +: W_ADDR];
            if (w_hit[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = 4'(i);
            end
        end
        o_hit = |w_hit;
    end

endmodule

// File: rtl/apb_splitter_wdog.sv
// apb_splitter_wdog: APB3 1-to-N splitter with priority decode, unmapped error and access watchdog
module apb_splitter_wdog
    import apb_splitter_wdog_pkg::*;
#(
    parameter int                         W_ADDR    = 16,
    parameter int                         W_DATA    = 32,
    parameter int                         N_SLAVES  = 3,
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MAP  = 48'h4000_2000_0000,
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MASK = 48'he000_e000_e000,
    parameter int                         TIMEOUT   = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [W_ADDR-1:0]            apbs_paddr,
    input  logic                         apbs_psel,
    input  logic                         apbs_penable,
    input  logic                         apbs_pwrite,
    input  logic [W_DATA-1:0]            apbs_pwdata,
    output logic                         apbs_pready,
    output logic [W_DATA-1:0]            apbs_prdata,
    output logic                         apbs_pslverr,
    output logic [N_SLAVES*W_ADDR-1:0]   apbm_paddr,
    output logic [N_SLAVES*W_DATA-1:0]   apbm_pwdata,
    output logic [N_SLAVES-1:0]          apbm_psel,
    output logic [N_SLAVES-1:0]          apbm_penable,
    output logic [N_SLAVES-1:0]          apbm_pwrite,
    input  logic [N_SLAVES-1:0]          apbm_pready,
    input  logic [N_SLAVES*W_DATA-1:0]   apbm_prdata,
    input  logic [N_SLAVES-1:0]          apbm_pslverr,
    input  logic                         err_clr,
    output logic [1:0]                   err_status,
    output logic [W_ADDR-1:0]            err_addr,
    output logic [3:0]                   err_slave
);

    localparam int               W_CNT    = cnt_width(TIMEOUT);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TIMEOUT - 1);
    localparam logic [W_CNT-1:0] CNT_MAX  = '1;

    state_t              r_state, w_state_nxt;
    logic [N_SLAVES-1:0] r_sel, w_sel, w_dec_oh;
    logic [3:0]          r_idx, w_dec_idx;
    logic [W_CNT-1:0]    r_cnt;
    logic                w_dec_hit, w_setup, w_rdy, w_slverr, w_timeout, w_unm;
    logic [1:0]          w_err_set;
    logic [W_DATA-1:0]   w_rdata;

    apb_priority_decode #(
        .W_ADDR (W_ADDR),
        .N      (N_SLAVES),
        .MAP    (ADDR_MAP),
        .MASK   (ADDR_MASK)
    ) u_decode (
        .i_addr   (apbs_paddr),
        .o_onehot (w_dec_oh),
        .o_hit    (w_dec_hit),
        .o_idx    (w_dec_idx)
    );

    assign w_setup    = (r_state == ST_IDLE) && apbs_psel && !apbs_penable;
    // Live decode only in a genuine setup phase, so a stray penable in IDLE selects nothing
    assign w_sel      = (r_state == ST_IDLE) ? (apbs_penable ? '0 : w_dec_oh) : r_sel;
    assign apbm_psel    = w_sel & {N_SLAVES{apbs_psel}};
    assign apbm_penable = w_sel & {N_SLAVES{apbs_penable}};
    assign apbm_pwrite  = w_sel & {N_SLAVES{apbs_pwrite}};
    assign apbm_paddr   = {N_SLAVES{apbs_paddr}};
    assign apbm_pwdata  = {N_SLAVES{apbs_pwdata}};
    assign w_rdy      = |(r_sel & apbm_pready);
    assign w_slverr   = |(r_sel & apbm_pslverr);
    assign w_timeout  = (TIMEOUT != 0) && (r_state == ST_ACCESS) && !w_rdy && (r_cnt == CNT_LAST);
    assign w_unm      = (r_state == ST_UNMAPPED);

    // One-hot read data mux driven by the select latched at setup
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++)
            w_rdata = w_rdata | (apbm_prdata[i*W_DATA +: W_DATA] & {W_DATA{r_sel[i]}});
    end

    // Next state and upstream response; an idle bus answers ready with no error
    always_comb begin
        w_state_nxt  = r_state;
        apbs_pready  = 1'b1;
        apbs_pslverr = 1'b0;
        apbs_prdata  = '0;
        w_err_set    = '0;
        w_err_set[ERR_UNMAPPED] = w_unm;
        w_err_set[ERR_TIMEOUT]  = w_timeout;
        case (r_state)
            ST_IDLE:     w_state_nxt = w_setup ? (w_dec_hit ? ST_ACCESS : ST_UNMAPPED) : ST_IDLE;
            ST_ACCESS: begin
                apbs_pready  = w_timeout | w_rdy;
                apbs_pslverr = w_timeout | w_slverr;
                apbs_prdata  = w_timeout ? '0 : w_rdata;
                w_state_nxt  = (w_timeout | w_rdy) ? ST_IDLE : ST_ACCESS;
            end
            ST_UNMAPPED: begin
                apbs_pslverr = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // State, latched select, saturating watchdog and sticky error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            err_status <= '0;
            err_addr   <= '0;
            err_slave  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_setup) begin
                r_sel <= w_dec_oh;
                r_idx <= w_dec_idx;
                r_cnt <= '0;
            end else if (r_state == ST_ACCESS && !w_rdy && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_err_set != '0 && (err_status == '0 || err_clr)) begin
                err_addr <= apbs_paddr;
                if (w_timeout)
                    err_slave <= r_idx;
            end
            err_status <= (err_clr ? 2'b00 : err_status) | w_err_set;
        end
    end

endmodule
